axi4_regbank_arbiter: RTL and testbench

Sequencer and arbiter between the AXI4 slave's write path (AW/W FIFO pop side) and read path (AR FIFO pop side) and a single-port register bank. Grants the bank to one direction at a time (round-robin) and walks INCR bursts beat by beat. Decodes addresses against the valid window and produces the B and R responses that feed the B/R FIFOs.

---
 rtl/axi4_regbank_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_axi4_regbank_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_regbank_arbiter.sv
// Write/read sequencer and round-robin arbiter in front of a single-port register bank.
// Optional macro REGBANK_WSTRB_EN passes wr_strb through to bank_wstrb; otherwise full-word writes only.
module axi4_regbank_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH = 4,
   parameter int LEN_WIDTH = 8,
   parameter int DEPTH = 64,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h0,
   parameter logic [ADDR_WIDTH-1:0] END_ADDR = 32'hFC
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       wr_req_valid,
   output logic                       wr_req_ready,
   input  logic [ID_WIDTH-1:0]        wr_req_id,
   input  logic [ADDR_WIDTH-1:0]      wr_req_addr,
   input  logic [LEN_WIDTH-1:0]       wr_req_len,
   input  logic                       wr_dat_valid,
   output logic                       wr_dat_ready,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic [DATA_WIDTH/8-1:0]    wr_strb,
   input  logic                       wr_last,
   input  logic                       rd_req_valid,
   output logic                       rd_req_ready,
   input  logic [ID_WIDTH-1:0]        rd_req_id,
   input  logic [ADDR_WIDTH-1:0]      rd_req_addr,
   input  logic [LEN_WIDTH-1:0]       rd_req_len,
   output logic                       bank_en,
   output logic                       bank_we,
   output logic [$clog2(DEPTH)-1:0]   bank_addr,
   output logic [DATA_WIDTH-1:0]      bank_wdata,
   output logic [DATA_WIDTH/8-1:0]    bank_wstrb,
   input  logic [DATA_WIDTH-1:0]      bank_rdata,
   output logic                       b_valid,
   input  logic                       b_ready,
   output logic [ID_WIDTH-1:0]        b_id,
   output logic [1:0]                 b_resp,
   output logic                       r_valid,
   input  logic                       r_ready,
   output logic [ID_WIDTH-1:0]        r_id,
   output logic [DATA_WIDTH-1:0]      r_data,
   output logic [1:0]                 r_resp,
   output logic                       r_last
);

   localparam int BANK_AW = $clog2(DEPTH);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] SPAN = END_ADDR - START_ADDR;

   typedef enum logic [2:0] {
      IDLE,
      WR_BURST,
      WR_RESP,
      RD_ISSUE,
      RD_DATA
   } state_t;

   state_t                  state;
   logic                    last_was_wr;
   logic [ID_WIDTH-1:0]     id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LEN_WIDTH-1:0]    len_q;
   logic [LEN_WIDTH-1:0]    beat_q;
   logic                    dec_err_q;
   logic                    slv_err_q;
   logic                    rd_first_q;
   logic [DATA_WIDTH-1:0]   r_data_q;

   logic [ADDR_WIDTH-1:0]   beat_addr;
   logic [ADDR_WIDTH-1:0]   beat_off;
   logic                    beat_ok;
   logic                    beat_is_last;
   logic                    grant_wr;
   logic                    grant_rd;
   logic                    wr_beat;
   logic                    wr_access;
   logic                    rd_access;
   logic                    wr_done;
   logic                    dec_err_nxt;
   logic                    slv_err_nxt;

   // Offset-based window check: addresses below START_ADDR wrap to a huge offset and fail too.
   assign beat_addr    = addr_q + ADDR_WIDTH'({beat_q, 2'b00});
   assign beat_off     = beat_addr - START_ADDR;
   assign beat_ok      = (beat_off <= SPAN);
   assign beat_is_last = (beat_q == len_q);

   // On a tie the direction not served last wins.
   assign grant_wr = (state == IDLE) && wr_req_valid && (!rd_req_valid || !last_was_wr);
   assign grant_rd = (state == IDLE) && rd_req_valid && !grant_wr;
   assign wr_req_ready = grant_wr;
   assign rd_req_ready = grant_rd;

   assign wr_dat_ready = (state == WR_BURST);
   assign wr_beat      = wr_dat_valid && wr_dat_ready;
   assign wr_access    = wr_beat && beat_ok;
   assign rd_access    = (state == RD_ISSUE) && beat_ok;
   assign wr_done      = wr_beat && (beat_is_last || wr_last);
   assign dec_err_nxt  = dec_err_q || (wr_beat && !beat_ok);
   assign slv_err_nxt  = slv_err_q || (wr_beat && (wr_last != beat_is_last));

   assign bank_en    = wr_access || rd_access;
   assign bank_we    = wr_access;
   assign bank_addr  = beat_off[BANK_AW+1:2];
   assign bank_wdata = wr_access ? wr_data : '0;

`ifdef REGBANK_WSTRB_EN
   assign bank_wstrb = wr_access ? wr_strb : '0;
`else
   // Strobes are forced high so every write updates the full word.
   assign bank_wstrb = wr_access ? (wr_strb | {STRB_W{1'b1}}) : '0;
`endif

   // Bank data arrives during the first RD_DATA cycle; afterwards the captured copy is held.
   always_comb begin
      r_data = r_data_q;
      if (rd_first_q) begin
         r_data = (r_resp == 2'b00) ? bank_rdata : '0;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= IDLE;
         last_was_wr <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         dec_err_q   <= 1'b0;
         slv_err_q   <= 1'b0;
         rd_first_q  <= 1'b0;
         r_data_q    <= '0;
         b_valid     <= 1'b0;
         b_id        <= '0;
         b_resp      <= 2'b00;
         r_valid     <= 1'b0;
         r_id        <= '0;
         r_resp      <= 2'b00;
         r_last      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  id_q        <= wr_req_id;
                  addr_q      <= wr_req_addr;
                  len_q       <= wr_req_len;
                  beat_q      <= '0;
                  dec_err_q   <= 1'b0;
                  slv_err_q   <= 1'b0;
                  last_was_wr <= 1'b1;
                  state       <= WR_BURST;
               end else if (grant_rd) begin
                  id_q        <= rd_req_id;
                  addr_q      <= rd_req_addr;
                  len_q       <= rd_req_len;
                  beat_q      <= '0;
                  dec_err_q   <= 1'b0;
                  slv_err_q   <= 1'b0;
                  last_was_wr <= 1'b0;
                  state       <= RD_ISSUE;
               end
            end

            WR_BURST: begin
               if (wr_beat) begin
                  dec_err_q <= dec_err_nxt;
                  slv_err_q <= slv_err_nxt;
                  if (wr_done) begin
                     b_valid <= 1'b1;
                     b_id    <= id_q;
                     b_resp  <= dec_err_nxt ? 2'b11 : (slv_err_nxt ? 2'b10 : 2'b00);
                     state   <= WR_RESP;
                  end else begin
                     beat_q <= beat_q + LEN_WIDTH'(1);
                  end
               end
            end

            WR_RESP: begin
               if (b_ready) begin
                  b_valid <= 1'b0;
                  state   <= IDLE;
               end
            end

            RD_ISSUE: begin
               r_valid    <= 1'b1;
               r_id       <= id_q;
               r_resp     <= beat_ok ? 2'b00 : 2'b11;
               r_last     <= beat_is_last;
               rd_first_q <= 1'b1;
               state      <= RD_DATA;
            end

            RD_DATA: begin
               rd_first_q <= 1'b0;
               r_data_q   <= r_data;
               if (r_ready) begin
                  r_valid <= 1'b0;
                  if (r_last) begin
                     state <= IDLE;
                  end else begin
                     beat_q <= beat_q + LEN_WIDTH'(1);
                     state  <= RD_ISSUE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_regbank_arbiter.sv
// Directed self-checking bench for axi4_regbank_arbiter with a behavioural register bank.
module tb_axi4_regbank_arbiter;

   logic        ACLK;
   logic        ARESET;
   logic        wr_req_valid, wr_req_ready;
   logic [3:0]  wr_req_id;
   logic [31:0] wr_req_addr;
   logic [7:0]  wr_req_len;
   logic        wr_dat_valid, wr_dat_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_last;
   logic        rd_req_valid, rd_req_ready;
   logic [3:0]  rd_req_id;
   logic [31:0] rd_req_addr;
   logic [7:0]  rd_req_len;
   logic        bank_en, bank_we;
   logic [5:0]  bank_addr;
   logic [31:0] bank_wdata;
   logic [3:0]  bank_wstrb;
   logic [31:0] bank_rdata;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;

   axi4_regbank_arbiter dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_id(wr_req_id),
      .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
      .wr_dat_valid(wr_dat_valid), .wr_dat_ready(wr_dat_ready), .wr_data(wr_data),
      .wr_strb(wr_strb), .wr_last(wr_last),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_id(rd_req_id),
      .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
      .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .bank_wstrb(bank_wstrb), .bank_rdata(bank_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
      .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
      .r_resp(r_resp), .r_last(r_last)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Synchronous single-port bank: read data appears the cycle after the strobe.
   logic [31:0] mem [64];
   always @(posedge ACLK) begin
      if (bank_en) begin
         if (bank_we) begin
            for (int i = 0; i < 4; i++) begin
               if (bank_wstrb[i]) mem[bank_addr][8*i +: 8] <= bank_wdata[8*i +: 8];
            end
         end else begin
            bank_rdata <= mem[bank_addr];
         end
      end
   end

   typedef struct packed {
      logic        we;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } acc_t;
   acc_t log_q[$];

   always @(negedge ACLK) begin
      if (bank_en) log_q.push_back(acc_t'{bank_we, bank_addr, bank_wdata, bank_wstrb});
   end

   int pass_cnt = 0;
   int total_cnt = 0;
   bit tmo;
   logic [31:0] wbeat [16];
   logic [3:0]  b_id_got;
   logic [1:0]  b_resp_got;
   logic [31:0] rd_data_got [16];
   logic [1:0]  rd_resp_got [16];
   logic        rd_last_got [16];
   logic [3:0]  rd_id_got;
   int          rd_n;

   function automatic acc_t log_at(input int i);
      return (i < log_q.size()) ? log_q[i] : acc_t'(0);
   endfunction

   task automatic wr_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      bit got = 0;
      int cyc = 0;
      wr_req_id = id; wr_req_addr = addr; wr_req_len = len; wr_req_valid = 1'b1;
      while (!got && cyc < 50) begin
         @(negedge ACLK); got = wr_req_ready;
         @(posedge ACLK); #1; cyc++;
      end
      if (!got) tmo = 1;
      wr_req_valid = 1'b0;
   endtask

   task automatic wr_beats(input int nbeats, input int last_idx, input logic [3:0] strb);
      for (int b = 0; b < nbeats; b++) begin
         bit got = 0;
         int cyc = 0;
         wr_dat_valid = 1'b1; wr_data = wbeat[b]; wr_strb = strb; wr_last = (b == last_idx);
         while (!got && cyc < 50) begin
            @(negedge ACLK); got = wr_dat_ready;
            @(posedge ACLK); #1; cyc++;
         end
         if (!got) tmo = 1;
      end
      wr_dat_valid = 1'b0; wr_last = 1'b0;
   endtask

   task automatic wr_bresp();
      bit got = 0;
      int cyc = 0;
      b_ready = 1'b1;
      while (!got && cyc < 50) begin
         @(negedge ACLK);
         if (b_valid) begin got = 1; b_id_got = b_id; b_resp_got = b_resp; end
         @(posedge ACLK); #1; cyc++;
      end
      if (!got) tmo = 1;
      b_ready = 1'b0;
   endtask

   task automatic wr_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input int nbeats, input int last_idx, input logic [3:0] strb);
      wr_req(id, addr, len);
      wr_beats(nbeats, last_idx, strb);
      wr_bresp();
   endtask

   task automatic rd_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      bit got = 0;
      int cyc = 0;
      rd_req_id = id; rd_req_addr = addr; rd_req_len = len; rd_req_valid = 1'b1;
      while (!got && cyc < 50) begin
         @(negedge ACLK); got = rd_req_ready;
         @(posedge ACLK); #1; cyc++;
      end
      if (!got) tmo = 1;
      rd_req_valid = 1'b0;
   endtask

   task automatic rd_txn(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      bit done = 0;
      int cyc = 0;
      rd_req(id, addr, len);
      rd_n = 0;
      r_ready = 1'b1;
      while (!done && cyc < 100) begin
         @(negedge ACLK);
         if (r_valid) begin
            rd_data_got[rd_n] = r_data; rd_resp_got[rd_n] = r_resp;
            rd_last_got[rd_n] = r_last; rd_id_got = r_id;
            rd_n++;
            done = r_last || (rd_n == 16);
         end
         @(posedge ACLK); #1; cyc++;
      end
      if (!done) tmo = 1;
      r_ready = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      total_cnt++;
      if ({wr_req_ready, rd_req_ready, wr_dat_ready} !== 3'b000)
         $display("[TB] FAIL reset_readies: got %b exp 000", {wr_req_ready, rd_req_ready, wr_dat_ready});
      else pass_cnt++;
      total_cnt++;
      if ({bank_en, bank_we} !== 2'b00)
         $display("[TB] FAIL reset_bank: got %b exp 00", {bank_en, bank_we});
      else pass_cnt++;
      total_cnt++;
      if ({b_valid, b_id, b_resp} !== 7'd0)
         $display("[TB] FAIL reset_b: got %h exp 0", {b_valid, b_id, b_resp});
      else pass_cnt++;
      total_cnt++;
      if ({r_valid, r_id, r_data, r_resp, r_last} !== 40'd0)
         $display("[TB] FAIL reset_r: got %h exp 0", {r_valid, r_id, r_data, r_resp, r_last});
      else pass_cnt++;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
   endtask

   task automatic test_round_robin();
      logic grants [4];
      int ng = 0;
      int cyc = 0;
      bit both = 0;
      wr_req_id = 4'h1; wr_req_addr = 32'h40; wr_req_len = 8'd0; wr_req_valid = 1'b1;
      rd_req_id = 4'h2; rd_req_addr = 32'h40; rd_req_len = 8'd0; rd_req_valid = 1'b1;
      wr_dat_valid = 1'b1; wr_data = 32'h55; wr_strb = 4'hF; wr_last = 1'b1;
      b_ready = 1'b1; r_ready = 1'b1;
      while (ng < 4 && cyc < 200) begin
         @(negedge ACLK);
         if (wr_req_ready && rd_req_ready) both = 1;
         if (wr_req_ready) begin grants[ng] = 1'b1; ng++; end
         else if (rd_req_ready) begin grants[ng] = 1'b0; ng++; end
         @(posedge ACLK); #1; cyc++;
      end
      wr_req_valid = 1'b0; rd_req_valid = 1'b0;
      repeat (10) @(posedge ACLK);
      #1;
      wr_dat_valid = 1'b0; wr_last = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
      total_cnt++;
      if (ng != 4) $display("[TB] FAIL rr_grant_count: got %0d exp 4", ng);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (i < ng && grants[i] !== ((i % 2) == 0))
            $display("[TB] FAIL rr_order[%0d]: got wr=%b exp wr=%b", i, grants[i], (i % 2) == 0);
         else if (i < ng) pass_cnt++;
         else $display("[TB] FAIL rr_order[%0d]: got none exp wr=%b", i, (i % 2) == 0);
      end
      total_cnt++;
      if (both) $display("[TB] FAIL rr_dual_ready: got 1 exp 0");
      else pass_cnt++;
   endtask

   task automatic test_single();
      acc_t a;
      tmo = 0;
      wbeat[0] = 32'hDEADBEEF;
      log_q.delete();
      wr_txn(4'h5, 32'h10, 8'd0, 1, 0, 4'hF);
      a = log_at(0);
      total_cnt++;
      if (log_q.size() != 1 || a !== acc_t'{1'b1, 6'd4, 32'hDEADBEEF, 4'hF})
         $display("[TB] FAIL single_write: got n=%0d %h exp n=1 %h", log_q.size(), a, acc_t'{1'b1, 6'd4, 32'hDEADBEEF, 4'hF});
      else pass_cnt++;
      total_cnt++;
      if ({b_id_got, b_resp_got} !== {4'h5, 2'b00})
         $display("[TB] FAIL single_b: got id=%h resp=%b exp id=5 resp=00", b_id_got, b_resp_got);
      else pass_cnt++;
      rd_txn(4'h9, 32'h10, 8'd0);
      total_cnt++;
      if (rd_n != 1 || {rd_id_got, rd_data_got[0], rd_resp_got[0], rd_last_got[0]} !== {4'h9, 32'hDEADBEEF, 2'b00, 1'b1})
         $display("[TB] FAIL single_read: got n=%0d id=%h data=%h resp=%b last=%b exp n=1 id=9 data=deadbeef resp=00 last=1",
                  rd_n, rd_id_got, rd_data_got[0], rd_resp_got[0], rd_last_got[0]);
      else pass_cnt++;
      total_cnt++;
      if (tmo) $display("[TB] FAIL single_timeout: got timeout exp handshakes");
      else pass_cnt++;
   endtask

   task automatic test_burst();
      tmo = 0;
      for (int i = 0; i < 4; i++) wbeat[i] = 32'(i + 1);
      log_q.delete();
      wr_txn(4'h2, 32'h0, 8'd3, 4, 3, 4'hF);
      total_cnt++;
      if (log_q.size() != 4) $display("[TB] FAIL burst_wr_count: got %0d exp 4", log_q.size());
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         acc_t a = log_at(i);
         total_cnt++;
         if (a !== acc_t'{1'b1, 6'(i), 32'(i + 1), 4'hF})
            $display("[TB] FAIL burst_wr[%0d]: got %h exp %h", i, a, acc_t'{1'b1, 6'(i), 32'(i + 1), 4'hF});
         else pass_cnt++;
      end
      total_cnt++;
      if (b_resp_got !== 2'b00) $display("[TB] FAIL burst_bresp: got %b exp 00", b_resp_got);
      else pass_cnt++;
      rd_txn(4'h3, 32'h0, 8'd3);
      total_cnt++;
      if (rd_n != 4) $display("[TB] FAIL burst_rd_count: got %0d exp 4", rd_n);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({rd_data_got[i], rd_resp_got[i], rd_last_got[i]} !== {32'(i + 1), 2'b00, i == 3})
            $display("[TB] FAIL burst_rd[%0d]: got data=%h resp=%b last=%b exp data=%h resp=00 last=%b",
                     i, rd_data_got[i], rd_resp_got[i], rd_last_got[i], i + 1, i == 3);
         else pass_cnt++;
      end
      total_cnt++;
      if (tmo) $display("[TB] FAIL burst_timeout: got timeout exp handshakes");
      else pass_cnt++;
   endtask

   task automatic test_boundary();
      logic [31:0] exp_d [3];
      logic [1:0]  exp_r [3];
      tmo = 0;
      wbeat[0] = 32'hA1; wbeat[1] = 32'hB2; wbeat[2] = 32'hC3;
      exp_d[0] = 32'hA1; exp_d[1] = 32'hB2; exp_d[2] = 32'h0;
      exp_r[0] = 2'b00;  exp_r[1] = 2'b00;  exp_r[2] = 2'b11;
      log_q.delete();
      wr_txn(4'h7, 32'hF8, 8'd2, 3, 2, 4'hF);
      total_cnt++;
      if (log_q.size() != 2 || log_at(0).addr !== 6'd62 || log_at(1).addr !== 6'd63)
         $display("[TB] FAIL bound_wr: got n=%0d a0=%0d a1=%0d exp n=2 a0=62 a1=63",
                  log_q.size(), log_at(0).addr, log_at(1).addr);
      else pass_cnt++;
      total_cnt++;
      if (b_resp_got !== 2'b11) $display("[TB] FAIL bound_bresp: got %b exp 11", b_resp_got);
      else pass_cnt++;
      rd_txn(4'h8, 32'hF8, 8'd2);
      total_cnt++;
      if (rd_n != 3) $display("[TB] FAIL bound_rd_count: got %0d exp 3", rd_n);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if ({rd_data_got[i], rd_resp_got[i], rd_last_got[i]} !== {exp_d[i], exp_r[i], i == 2})
            $display("[TB] FAIL bound_rd[%0d]: got data=%h resp=%b last=%b exp data=%h resp=%b last=%b",
                     i, rd_data_got[i], rd_resp_got[i], rd_last_got[i], exp_d[i], exp_r[i], i == 2);
         else pass_cnt++;
      end
      total_cnt++;
      if (tmo) $display("[TB] FAIL bound_timeout: got timeout exp handshakes");
      else pass_cnt++;
   endtask

   task automatic test_early_last_and_stall();
      bit got = 0;
      int cyc = 0;
      tmo = 0;
      wbeat[0] = 32'h1111; wbeat[1] = 32'h2222;
      log_q.delete();
      wr_txn(4'h4, 32'h20, 8'd3, 2, 1, 4'hF);
      total_cnt++;
      if (b_resp_got !== 2'b10) $display("[TB] FAIL early_bresp: got %b exp 10", b_resp_got);
      else pass_cnt++;
      total_cnt++;
      if (log_q.size() != 2 || log_at(0).addr !== 6'd8 || log_at(1).addr !== 6'd9)
         $display("[TB] FAIL early_wr: got n=%0d a0=%0d a1=%0d exp n=2 a0=8 a1=9",
                  log_q.size(), log_at(0).addr, log_at(1).addr);
      else pass_cnt++;
      rd_req(4'hA, 32'h24, 8'd0);
      r_ready = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge ACLK); got = r_valid;
         if (!got) begin @(posedge ACLK); #1; end
         cyc++;
      end
      if (!got) tmo = 1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge ACLK);
         total_cnt++;
         if ({r_valid, r_resp, r_data} !== {1'b1, 2'b00, 32'h2222})
            $display("[TB] FAIL stall[%0d]: got valid=%b resp=%b data=%h exp valid=1 resp=00 data=00002222",
                     k, r_valid, r_resp, r_data);
         else pass_cnt++;
         @(posedge ACLK); #1;
      end
      r_ready = 1'b1;
      @(posedge ACLK); #1;
      r_ready = 1'b0;
      @(negedge ACLK);
      total_cnt++;
      if (r_valid !== 1'b0) $display("[TB] FAIL stall_release: got r_valid=%b exp 0", r_valid);
      else pass_cnt++;
      @(posedge ACLK); #1;
      total_cnt++;
      if (tmo) $display("[TB] FAIL early_timeout: got timeout exp handshakes");
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_burst_and_strb();
      logic [3:0]  exp_strb;
      logic [31:0] exp_word;
`ifdef REGBANK_WSTRB_EN
      exp_strb = 4'b0011; exp_word = 32'h1122CCDD;
`else
      exp_strb = 4'b1111; exp_word = 32'hAABBCCDD;
`endif
      tmo = 0;
      wbeat[0] = 32'h11223344;
      wr_txn(4'h1, 32'h50, 8'd0, 1, 0, 4'hF);
      wbeat[0] = 32'h77;
      wr_req(4'h3, 32'h30, 8'd3);
      wr_beats(1, 3, 4'hF);
      wr_dat_valid = 1'b1; wr_data = 32'h88;
      ARESET = 1'b1;
      @(negedge ACLK);
      total_cnt++;
      if ({wr_dat_ready, bank_en, bank_we, b_valid, r_valid, wr_req_ready, rd_req_ready} !== 7'd0)
         $display("[TB] FAIL midreset_outputs: got %b exp 0000000",
                  {wr_dat_ready, bank_en, bank_we, b_valid, r_valid, wr_req_ready, rd_req_ready});
      else pass_cnt++;
      @(posedge ACLK); #1;
      wr_dat_valid = 1'b0;
      ARESET = 1'b0;
      @(posedge ACLK); #1;
      wr_req_id = 4'hC; wr_req_addr = 32'h50; wr_req_len = 8'd0; wr_req_valid = 1'b1;
      rd_req_id = 4'hD; rd_req_addr = 32'h50; rd_req_len = 8'd0; rd_req_valid = 1'b1;
      @(negedge ACLK);
      total_cnt++;
      if ({wr_req_ready, rd_req_ready} !== 2'b10)
         $display("[TB] FAIL midreset_tie: got wr=%b rd=%b exp wr=1 rd=0", wr_req_ready, rd_req_ready);
      else pass_cnt++;
      @(posedge ACLK); #1;
      wr_req_valid = 1'b0; rd_req_valid = 1'b0;
      log_q.delete();
      wbeat[0] = 32'hAABBCCDD;
      wr_beats(1, 0, 4'b0011);
      wr_bresp();
      total_cnt++;
      if (log_q.size() != 1 || log_at(0).strb !== exp_strb || log_at(0).addr !== 6'd20)
         $display("[TB] FAIL strb_write: got n=%0d strb=%b addr=%0d exp n=1 strb=%b addr=20",
                  log_q.size(), log_at(0).strb, log_at(0).addr, exp_strb);
      else pass_cnt++;
      rd_txn(4'hD, 32'h50, 8'd0);
      total_cnt++;
      if (rd_n != 1 || rd_data_got[0] !== exp_word)
         $display("[TB] FAIL strb_readback: got n=%0d data=%h exp n=1 data=%h", rd_n, rd_data_got[0], exp_word);
      else pass_cnt++;
      total_cnt++;
      if (tmo) $display("[TB] FAIL midreset_timeout: got timeout exp handshakes");
      else pass_cnt++;
   endtask

   initial begin
      ARESET = 1'b1;
      wr_req_valid = 1'b0; wr_req_id = '0; wr_req_addr = '0; wr_req_len = '0;
      wr_dat_valid = 1'b0; wr_data = '0; wr_strb = '0; wr_last = 1'b0;
      rd_req_valid = 1'b0; rd_req_id = '0; rd_req_addr = '0; rd_req_len = '0;
      b_ready = 1'b0; r_ready = 1'b0;
      tmo = 0;
      test_reset();
      test_round_robin();
      test_single();
      test_burst();
      test_boundary();
      test_early_last_and_stall();
      test_reset_mid_burst_and_strb();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish exp finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
